// File: rtl/board_lock_pkg.sv
// tetris_pkg: playfield geometry, lock-sequence states and shape/score helpers shared by the board stages
package tetris_pkg;

    localparam int CELL = 20;
    localparam int COLS = 9;
    localparam int ROWS = 24;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    localparam logic [9:0] CELL_P = 10'(CELL);
    localparam logic [9:0] COLS_P = 10'(COLS);
    localparam logic [9:0] ROWS_P = 10'(ROWS);
    localparam logic [9:0] XMAX_P = 10'(COLS * CELL);
    localparam logic [9:0] YMAX_P = 10'(ROWS * CELL);

    typedef enum logic [2:0] {IDLE, CONV, WRITE, SCAN, SHIFT, DONE} lock_state_e;

    function automatic logic [3:0] bit_idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

    function automatic logic [3:0] score_pts(input logic [2:0] n);
        return n == 3'd0 ? 4'd0 : n == 3'd1 ? 4'd1 : n == 3'd2 ? 4'd3 : n == 3'd3 ? 4'd5 : 4'd8;
    endfunction

endpackage

// File: rtl/board_lock_if.sv
// board_lock_if: piece hand-off, VGA query and status signals between the falling-block stage, the board and the colour mapper
interface board_lock_if;
    logic        lock_req;
    logic [9:0]  Block_X_Pos;
    logic [9:0]  Block_Y_Pos;
    logic [15:0] blockstate;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        busy;
    logic        spawn_req;
    logic        drawCell;
    logic [15:0] lines_cleared;
    logic        game_over;
    logic [15:0] score;

    modport master (
        output lock_req, Block_X_Pos, Block_Y_Pos, blockstate, DrawX, DrawY,
        input  busy, spawn_req, drawCell, lines_cleared, game_over, score
    );

    modport slave (
        input  lock_req, Block_X_Pos, Block_Y_Pos, blockstate, DrawX, DrawY,
        output busy, spawn_req, drawCell, lines_cleared, game_over, score
    );
endinterface

// File: rtl/board_lock_cell_divider.sv
// cell_divider: floor(value / CELL) by repeated subtraction, one CELL per clock
module cell_divider
    import tetris_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic [9:0] value,
    output logic [9:0] quotient,
    output logic       done
);
    logic [9:0] rem_q;
    logic [9:0] quo_q;

    // load on start, then peel off one CELL per cycle until the remainder fits
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (start) begin
            rem_q <= value;
            quo_q <= '0;
        end else if (rem_q >= CELL_P) begin
            rem_q <= rem_q - CELL_P;
            quo_q <= quo_q + 10'd1;
        end
    end

    assign quotient = quo_q;
    assign done     = !start && rem_q < CELL_P;
endmodule

// File: rtl/board_lock.sv
// board_lock: locks a landed piece into the playfield, clears full rows and requests the next piece; BOARD_SCORE_EN enables scoring
module board_lock
    import tetris_pkg::*;
(
    input logic         Clk,
    input logic         Reset_n,
    board_lock_if.slave bus
);
    lock_state_e     state_q, state_d;
    logic [COLS-1:0] board_q [ROWS];
    logic [COLS-1:0] board_d [ROWS];
    logic [15:0]     shape_q;
    logic [1:0]      wr_q;
    logic [RW-1:0]   idx_q;
    logic [15:0]     lines_q;
    logic            go_q;
    logic [9:0]      row;
    logic [9:0]      col;
    logic            row_done;
    logic            col_done;
    logic            accept;
    logic            hit;
    logic            full;
    logic [9:0]      trow;
    logic [9:0]      tcol;

    assign accept = state_q == IDLE && bus.lock_req;
    assign full   = &board_q[idx_q];
    assign trow   = row + 10'(wr_q);

    cell_divider u_div_x (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (accept),
        .value    (bus.Block_X_Pos),
        .quotient (col),
        .done     (col_done)
    );

    cell_divider u_div_y (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (accept),
        .value    (bus.Block_Y_Pos),
        .quotient (row),
        .done     (row_done)
    );

    // WRITE drops one shape row onto the board; SHIFT pulls every row above k down by one
    always_comb begin
        board_d = board_q;
        hit     = 1'b0;
        tcol    = '0;
        if (state_q == WRITE && trow < ROWS_P) begin
            for (int c = 0; c < 4; c++) begin
                tcol = col + 10'(c);
                if (shape_q[bit_idx(wr_q, 2'(c))] && tcol < COLS_P) begin
                    hit = hit | board_q[RW'(trow)][CW'(tcol)];
                    board_d[RW'(trow)][CW'(tcol)] = 1'b1;
                end
            end
        end
        if (state_q == SHIFT) begin
            for (int j = 1; j < ROWS; j++)
                if (RW'(j) <= idx_q) board_d[j] = board_q[j-1];
            board_d[0] = '0;
        end
    end

    // sequence: accept, convert, write four rows, scan bottom-up with shifts, announce
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.lock_req ? CONV : IDLE;
            CONV:    state_d = (row_done && col_done) ? WRITE : CONV;
            WRITE:   state_d = wr_q == 2'd3 ? SCAN : WRITE;
            SCAN:    state_d = full ? SHIFT : (idx_q == '0 ? DONE : SCAN);
            SHIFT:   state_d = SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // board, latched shape, row cursors and the line / collision status
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            board_q <= '{default: '0};
            shape_q <= '0;
            wr_q    <= '0;
            idx_q   <= '0;
            lines_q <= '0;
            go_q    <= 1'b0;
        end else begin
            board_q <= board_d;
            if (accept) begin
                shape_q <= bus.blockstate;
                wr_q    <= '0;
                idx_q   <= RW'(ROWS - 1);
            end
            if (state_q == WRITE) begin
                wr_q <= wr_q + 2'd1;
                go_q <= go_q | hit;
            end
            if (state_q == SCAN && !full && idx_q != '0) idx_q <= idx_q - RW'(1);
            if (state_q == SHIFT && lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
        end
    end

`ifdef BOARD_SCORE_EN
    logic [2:0]  cnt_q;
    logic [15:0] score_q;
    logic [16:0] sum;

    assign sum = {1'b0, score_q} + 17'(score_pts(cnt_q));

    // rows cleared by this lock, turned into points once the board settles
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q   <= '0;
            score_q <= '0;
        end else begin
            if (accept) cnt_q <= '0;
            else if (state_q == SHIFT && cnt_q != 3'd7) cnt_q <= cnt_q + 3'd1;
            if (state_q == DONE) score_q <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end

    assign bus.score = score_q;
`else
    assign bus.score = '0;
`endif

    assign bus.busy          = state_q != IDLE;
    assign bus.spawn_req     = state_q == DONE;
    assign bus.lines_cleared = lines_q;
    assign bus.game_over     = go_q;
    assign bus.drawCell      = (bus.DrawX < XMAX_P && bus.DrawY < YMAX_P) ?
                               board_q[RW'(bus.DrawY / CELL_P)][CW'(bus.DrawX / CELL_P)] : 1'b0;
endmodule
